bsg_imul_add_seq: RTL and testbench

Sequential multiply-add that rebuilds a numerator from a quotient, a denominator and a remainder: numer = quot*denom + rem. It is the inverse of the integer modulo/divide datapath and is used to check or reconstruct values downstream of it. It is a shift-add engine with a single operation in flight. Input side is valid/ready; output side is valid/yumi.

---
 rtl/bsg_imul_add_pkg.sv | 28 ++
 rtl/bsg_imul_add_seq.sv | 179 +++++++++++++++++
 tb/tb_bsg_imul_add_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_imul_add_pkg.sv
// ----------------------------------------------------------------------------
// bsg_imul_add_pkg
//
// Shared types and helpers for the sequential multiply-add engine
// bsg_imul_add_seq.
//
// Contents:
//   state_e       - engine state encoding (idle / busy / done)
//   cnt_width_f() - width of the step counter for a given quotient width
// ----------------------------------------------------------------------------
package bsg_imul_add_pkg;

   typedef enum logic [1:0] {
      eIdle = 2'd0,
      eBusy = 2'd1,
      eDone = 2'd2
   } state_e;

   // The step counter must hold the values 0 .. quot_width.
   // Widths below one bit are clamped so the counter always exists.
   function automatic int cnt_width_f(input int quot_width);
      if (quot_width < 1) begin
         return 1;
      end
      return $clog2(quot_width + 1);
   endfunction

endpackage : bsg_imul_add_pkg

// File: rtl/bsg_imul_add_seq.sv
// ----------------------------------------------------------------------------
// bsg_imul_add_seq
//
// Sequential shift-add multiply-add: numer_o = quot_i * denom_i + rem_i.
// Rebuilds a numerator from the outputs of an integer divide/modulo unit.
// One operation in flight; fixed latency of quot_width_p busy cycles
// (no early exit on a zero quotient).
//
// Handshake:
//   input  side valid/ready : operands accepted on v_i & ready_o.
//   output side valid/yumi  : result held in DONE until yumi_i.
//
// Ports:
//   clk_i     in   1              clock
//   reset_i   in   1              asynchronous active-high reset
//   v_i       in   1              operands valid
//   ready_o   out  1              engine idle and out of reset
//   quot_i    in   quot_width_p   quotient
//   denom_i   in   denom_width_p  denominator
//   rem_i     in   denom_width_p  remainder
//   v_o       out  1              result valid
//   numer_o   out  numer_width_p  quot*denom + rem (zero outside DONE)
//   yumi_i    in   1              consumer takes result (only while v_o=1)
//   error_o   out  1              rem >= denom flag, only with the macro
//
// Configuration macro:
//   BSG_IMUL_ADD_SEQ_REM_CHECK_EN - adds error_o and its capture flag.
//
// The accumulator is quot_width_p+denom_width_p bits; the largest possible
// result 2^Q*(2^D-1) fits, so no overflow is possible even when the
// remainder is not smaller than the denominator.
// ----------------------------------------------------------------------------
module bsg_imul_add_seq
   import bsg_imul_add_pkg::*;
#(
   parameter  int quot_width_p  = 8,
   parameter  int denom_width_p = 8,
   localparam int numer_width_p = quot_width_p + denom_width_p
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [quot_width_p-1:0]  quot_i,
   input  logic [denom_width_p-1:0] denom_i,
   input  logic [denom_width_p-1:0] rem_i,

   output logic                     v_o,
   output logic [numer_width_p-1:0] numer_o,
   input  logic                     yumi_i
`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
   ,
   output logic                     error_o
`endif
);

   localparam int cnt_width_lp = cnt_width_f(quot_width_p);
   localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(quot_width_p - 1);

   state_e                   state_q, state_d;
   logic [numer_width_p-1:0] acc_q,   acc_d;
   logic [numer_width_p-1:0] mcand_q, mcand_d;
   logic [quot_width_p-1:0]  qsh_q,   qsh_d;
   logic [cnt_width_lp-1:0]  cnt_q,   cnt_d;

   logic accept;

   // Handshake qualified with reset so nothing is taken while reset is held.
   assign accept = (state_q == eIdle) && v_i && !reset_i;

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a signal unassigned (no latch).
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      qsh_d   = qsh_q;
      cnt_d   = cnt_q;
      ready_o = 1'b0;
      v_o     = 1'b0;
      numer_o = '0;

      unique case (state_q)
         eIdle: begin
            ready_o = !reset_i;
            if (accept) begin
               acc_d   = {{quot_width_p{1'b0}}, rem_i};
               mcand_d = {{quot_width_p{1'b0}}, denom_i};
               qsh_d   = quot_i;
               cnt_d   = '0;
               state_d = eBusy;
            end
         end

         eBusy: begin
            // One partial product per cycle, LSB of the quotient first.
            if (qsh_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            qsh_d   = qsh_q >> 1;
            cnt_d   = cnt_q + cnt_width_lp'(1);
            if (cnt_q == last_cnt_lp) begin
               state_d = eDone;
            end
         end

         eDone: begin
            v_o     = 1'b1;
            numer_o = acc_q;
            if (yumi_i) begin
               state_d = eIdle;
            end
         end

         default: begin
            state_d = eIdle;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= eIdle;
         acc_q   <= '0;
         mcand_q <= '0;
         qsh_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         qsh_q   <= qsh_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
   // -------------------------------------------------------------------------
   // Remainder range flag: captured at acceptance, cleared when the result
   // is consumed. A zero denominator always sets it.
   // -------------------------------------------------------------------------
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept) begin
         err_d = (rem_i >= denom_i);
      end else if ((state_q == eDone) && yumi_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign error_o = err_q & v_o;
`endif

   // yumi_i is only meaningful while a result is presented.
   yumi_only_in_done_a : assert property (
      @(posedge clk_i) disable iff (reset_i) yumi_i |-> (state_q == eDone)
   );

endmodule : bsg_imul_add_seq

// File: tb/tb_bsg_imul_add_seq.sv
// ----------------------------------------------------------------------------
// tb_bsg_imul_add_seq
//
// Self-checking bench for bsg_imul_add_seq with Q=D=8. Expected results are
// pushed to a scoreboard queue when operands are accepted and popped when
// the DUT presents v_o. Directed vectors come from a table; reset abort and
// a random phase with random consumer delays follow.
// ----------------------------------------------------------------------------
module tb_bsg_imul_add_seq;

   localparam int Q = 8;
   localparam int D = 8;
   localparam int N = Q + D;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         v_i;
   logic         ready_o;
   logic [Q-1:0] quot_i;
   logic [D-1:0] denom_i;
   logic [D-1:0] rem_i;
   logic         v_o;
   logic [N-1:0] numer_o;
   logic         yumi_i;
`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
   logic         error_o;
`endif

   bsg_imul_add_seq #(
      .quot_width_p (Q),
      .denom_width_p(D)
   ) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .v_i    (v_i),
      .ready_o(ready_o),
      .quot_i (quot_i),
      .denom_i(denom_i),
      .rem_i  (rem_i),
      .v_o    (v_o),
      .numer_o(numer_o),
      .yumi_i (yumi_i)
`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
      ,
      .error_o(error_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [Q-1:0] q;
      logic [D-1:0] d;
      logic [D-1:0] r;
      logic [N-1:0] numer;
      logic         err;
      int           ydel;
   } vec_t;

   typedef struct {
      logic [N-1:0] numer;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drive one operation, wait for its result, hold yumi_i low for ydel
   // cycles, then consume it.
   task automatic run_op(input logic [Q-1:0] q, input logic [D-1:0] d, input logic [D-1:0] r,
                         input logic [N-1:0] en, input logic ee, input int ydel);
      int           cyc;
      logic         busy_ready;
      logic         stable;
      logic [N-1:0] held;
      exp_t         e;

      cyc = 0;
      while (!ready_o && cyc < 50) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      check("ready_wait", {31'd0, ready_o}, 32'd1);
      if (!ready_o) return;

      v_i = 1'b1; quot_i = q; denom_i = d; rem_i = r;
      sb.push_back('{numer: en, err: ee});
      @(posedge clk_i); #1;

      // While busy, throw junk at the input; none of it may be accepted.
      cyc = 0;
      busy_ready = 1'b0;
      while (!v_o && cyc < 100) begin
         if (ready_o) busy_ready = 1'b1;
         v_i     = 1'($urandom_range(0, 1));
         quot_i  = Q'($urandom);
         denom_i = D'($urandom);
         rem_i   = D'($urandom);
         @(posedge clk_i); #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'(Q));
      check("busy_ready", {31'd0, busy_ready}, 32'd0);
      e = sb.pop_front();
      if (!v_o) begin
         v_i = 1'b0;
         return;
      end

      held   = numer_o;
      stable = 1'b1;
      for (int i = 0; i < ydel; i++) begin
         v_i = 1'($urandom_range(0, 1));
         @(posedge clk_i); #1;
         if (!v_o || numer_o !== held || ready_o) stable = 1'b0;
      end
      if (ydel > 0) check("hold_stable", {31'd0, stable}, 32'd1);

      check("numer", 32'(numer_o), 32'(e.numer));
`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
      check("error", {31'd0, error_o}, {31'd0, e.err});
`endif

      v_i    = 1'b0;
      yumi_i = 1'b1;
      @(posedge clk_i); #1;
      yumi_i = 1'b0;
      check("ready_after_yumi", {31'd0, ready_o}, 32'd1);
      check("v_o_after_yumi", {31'd0, v_o}, 32'd0);
`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
      check("error_after_yumi", {31'd0, error_o}, 32'd0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[8];
      logic [Q-1:0] rq;
      logic [D-1:0] rd;
      logic [D-1:0] rr;
      logic [N-1:0] model;

      vecs[0] = '{q: 8'h2A, d: 8'h0D, r: 8'h05, numer: 16'h0227, err: 1'b0, ydel: 0};
      vecs[1] = '{q: 8'hFF, d: 8'hFF, r: 8'hFE, numer: 16'hFEFF, err: 1'b0, ydel: 1};
      vecs[2] = '{q: 8'h00, d: 8'h44, r: 8'h33, numer: 16'h0033, err: 1'b0, ydel: 0};
      vecs[3] = '{q: 8'h2A, d: 8'h0D, r: 8'h14, numer: 16'h0236, err: 1'b1, ydel: 5};
      vecs[4] = '{q: 8'h55, d: 8'h00, r: 8'h00, numer: 16'h0000, err: 1'b1, ydel: 2};
      vecs[5] = '{q: 8'h03, d: 8'h07, r: 8'h01, numer: 16'h0016, err: 1'b0, ydel: 0};
      vecs[6] = '{q: 8'h01, d: 8'hFF, r: 8'hFF, numer: 16'h01FE, err: 1'b1, ydel: 3};
      vecs[7] = '{q: 8'h80, d: 8'h01, r: 8'h00, numer: 16'h0080, err: 1'b0, ydel: 0};

      reset_i = 1'b1;
      v_i     = 1'b0;
      yumi_i  = 1'b0;
      quot_i  = '0;
      denom_i = '0;
      rem_i   = '0;

      #3;
      check("reset_ready", {31'd0, ready_o}, 32'd0);
      check("reset_v_o", {31'd0, v_o}, 32'd0);
      check("reset_numer", 32'(numer_o), 32'd0);
`ifdef BSG_IMUL_ADD_SEQ_REM_CHECK_EN
      check("reset_error", {31'd0, error_o}, 32'd0);
`endif
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      #1;
      check("ready_after_reset", {31'd0, ready_o}, 32'd1);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].numer, vecs[i].err, vecs[i].ydel);
      end

      // Reset during BUSY step 4 aborts the operation.
      v_i = 1'b1; quot_i = 8'h2A; denom_i = 8'h0D; rem_i = 8'h05;
      @(posedge clk_i); #1;
      v_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      reset_i = 1'b1;
      #1;
      check("abort_v_o", {31'd0, v_o}, 32'd0);
      check("abort_numer", 32'(numer_o), 32'd0);
      check("abort_ready", {31'd0, ready_o}, 32'd0);
      @(posedge clk_i); #1;
      check("abort_v_o_held", {31'd0, v_o}, 32'd0);
      reset_i = 1'b0;
      @(posedge clk_i); #1;
      check("abort_ready_after", {31'd0, ready_o}, 32'd1);
      check("abort_no_v_o", {31'd0, v_o}, 32'd0);
      run_op(8'h03, 8'h07, 8'h01, 16'h0016, 1'b0, 0);

      // Random operations with random consumer delay.
      for (int n = 0; n < 2000; n++) begin
         rq    = Q'($urandom);
         rd    = D'($urandom);
         rr    = D'($urandom);
         model = N'(rq) * N'(rd) + N'(rr);
         run_op(rq, rd, rr, model, (rr >= rd), int'($urandom_range(0, 3)));
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bsg_imul_add_seq
